// File: rtl/timing_gen_if.sv
// rtl/timing_gen_if.sv - drum timing generator port bundle (bit strobe/origin in, counts and decodes out)
interface timing_gen_if;
    logic       bit_en;
    logic       origin;
    logic [4:0] BT;
    logic [6:0] WT;
    logic       T0;
    logic       T1;
    logic       T2;
    logic       T13;
    logic       T21;
    logic       T28;
    logic       T29;
    logic       TE;
    logic       TF;
    logic       TS;
    logic       CR;
    logic       locked;
    logic       sync_err;

    modport master (
        output bit_en, origin,
        input  BT, WT, T0, T1, T2, T13, T21, T28, T29, TE, TF, TS, CR, locked, sync_err
    );

    modport slave (
        input  bit_en, origin,
        output BT, WT, T0, T1, T2, T13, T21, T28, T29, TE, TF, TS, CR, locked, sync_err
    );
endinterface

// File: rtl/timing_gen.sv
// rtl/timing_gen.sv - G-15 drum timing generator: bit/word counters, decoded strobes, origin HUNT/LOCK
module timing_gen #(
    parameter int BITS_PER_WORD = 29,
    parameter int WORDS_PER_REV = 108,
    parameter int MISS_LIMIT    = 2
) (
    input  logic         CLOCK,
    input  logic         rst_n,
    timing_gen_if.slave  tg
);

    localparam logic [4:0] BT_LAST = 5'(BITS_PER_WORD - 1);
    localparam logic [6:0] WT_LAST = 7'(WORDS_PER_REV - 1);
    localparam logic [3:0] MISS_MAX = 4'(MISS_LIMIT);

    typedef enum logic {HUNT, LOCK} state_t;

    state_t     state_q, state_d;
    logic [4:0] bt_q, bt_d;
    logic [6:0] wt_q, wt_d;
    logic [3:0] miss_q, miss_d;
    logic       err_q, err_d;
    logic [6:0] tstr_q, tstr_d;
    logic       te_q, te_d;
    logic       tf_q, tf_d;
    logic       ts_q, ts_d;

    logic       at_origin;
    logic       lock_d;

    // Origin belongs on the bit time that follows the last bit of the last word.
    assign at_origin = (bt_q == BT_LAST) && (wt_q == WT_LAST);

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            bt_q    <= '0;
            wt_q    <= '0;
            miss_q  <= '0;
            err_q   <= 1'b0;
            tstr_q  <= '0;
            te_q    <= 1'b0;
            tf_q    <= 1'b0;
            ts_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            bt_q    <= bt_d;
            wt_q    <= wt_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
            tstr_q  <= tstr_d;
            te_q    <= te_d;
            tf_q    <= tf_d;
            ts_q    <= ts_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bt_d    = bt_q;
        wt_d    = wt_q;
        miss_d  = miss_q;
        err_d   = 1'b0;

        if (tg.bit_en) begin
            if (bt_q == BT_LAST) begin
                bt_d = '0;
                wt_d = (wt_q == WT_LAST) ? 7'd0 : wt_q + 7'd1;
            end else begin
                bt_d = bt_q + 5'd1;
            end

            case (state_q)
                HUNT: begin
                    if (tg.origin) begin
                        bt_d    = '0;
                        wt_d    = '0;
                        miss_d  = '0;
                        state_d = LOCK;
                    end
                end
                LOCK: begin
                    if (tg.origin && at_origin) begin
                        miss_d = '0;
                    end else if (tg.origin || at_origin) begin
                        err_d = 1'b1;
                        // An early origin wins over the normal increment.
                        if (tg.origin) begin
                            bt_d = '0;
                            wt_d = '0;
                        end
                        if (miss_q + 4'd1 >= MISS_MAX) begin
                            miss_d  = '0;
                            state_d = HUNT;
                        end else begin
                            miss_d = miss_q + 4'd1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Decodes are computed from the next counts so they register alongside BT/WT.
    always_comb begin
        lock_d = (state_d == LOCK);
        tstr_d = '0;
        te_d   = 1'b0;
        tf_d   = 1'b0;
        ts_d   = 1'b0;
        if (lock_d) begin
            tstr_d[6] = (bt_d == 5'd28);
            tstr_d[5] = (bt_d == 5'd0);
            tstr_d[4] = (bt_d == 5'd1);
            tstr_d[3] = (bt_d == 5'd12);
            tstr_d[2] = (bt_d == 5'd20);
            tstr_d[1] = (bt_d == 5'd27);
            tstr_d[0] = (bt_d == 5'd28);
            te_d      = ~wt_d[0];
            tf_d      = (wt_d == WT_LAST);
            ts_d      = (bt_d == BT_LAST) && (wt_d[1:0] == 2'b11);
        end
    end

    assign tg.BT       = bt_q;
    assign tg.WT       = wt_q;
    assign tg.T0       = tstr_q[6];
    assign tg.T1       = tstr_q[5];
    assign tg.T2       = tstr_q[4];
    assign tg.T13      = tstr_q[3];
    assign tg.T21      = tstr_q[2];
    assign tg.T28      = tstr_q[1];
    assign tg.T29      = tstr_q[0];
    assign tg.TE       = te_q;
    assign tg.TF       = tf_q;
    assign tg.TS       = ts_q;
    assign tg.locked   = (state_q == LOCK);
    assign tg.CR       = (state_q == LOCK) && tg.bit_en;
    assign tg.sync_err = err_q;

endmodule

// File: tb/tb_timing_gen.sv
// tb/tb_timing_gen.sv - scoreboard bench for timing_gen
module tb_timing_gen;

    logic CLOCK;
    logic rst_n;

    timing_gen_if tg ();

    timing_gen dut (
        .CLOCK (CLOCK),
        .rst_n (rst_n),
        .tg    (tg.slave)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int errors = 0;

    // Reference state of the drum timing
    int m_bt   = 0;
    int m_wt   = 0;
    bit m_lock = 0;
    int m_miss = 0;
    bit m_err  = 0;

    logic [23:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] dut_snap();
        return {tg.BT, tg.WT, tg.T0, tg.T1, tg.T2, tg.T13, tg.T21, tg.T28, tg.T29,
                tg.TE, tg.TF, tg.TS, tg.locked, tg.sync_err};
    endfunction

    function automatic logic [23:0] exp_snap();
        logic lk;
        lk = m_lock;
        return {5'(m_bt), 7'(m_wt),
                lk && (m_bt == 28), lk && (m_bt == 0), lk && (m_bt == 1), lk && (m_bt == 12),
                lk && (m_bt == 20), lk && (m_bt == 27), lk && (m_bt == 28),
                lk && (m_wt % 2 == 0), lk && (m_wt == 107),
                lk && (m_bt == 28) && (m_wt % 4 == 3),
                lk, m_err};
    endfunction

    task automatic model_step(input bit org);
        bit at_org;
        at_org = (m_bt == 28) && (m_wt == 107);
        m_err  = 0;
        m_bt   = m_bt + 1;
        if (m_bt == 29) begin
            m_bt = 0;
            m_wt = (m_wt == 107) ? 0 : m_wt + 1;
        end
        if (!m_lock) begin
            if (org) begin
                m_bt = 0; m_wt = 0; m_lock = 1; m_miss = 0;
            end
        end else if (org && at_org) begin
            m_miss = 0;
        end else if (org) begin
            m_err = 1; m_bt = 0; m_wt = 0; m_miss++;
        end else if (at_org) begin
            m_err = 1; m_miss++;
        end
        if (m_miss == 2) begin
            m_lock = 0; m_miss = 0;
        end
    endtask

    task automatic step(input bit org);
        @(negedge CLOCK);
        tg.bit_en = 1'b1;
        tg.origin = org;
        #1;
        chk("cr_during_bit", {31'd0, tg.CR}, {31'd0, m_lock});
        @(posedge CLOCK);
        #1;
        tg.bit_en = 1'b0;
        tg.origin = 1'b0;
        model_step(org);
        exp_q.push_back(exp_snap());
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic drain();
        int budget;
        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge CLOCK);
            budget--;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    always @(negedge CLOCK) begin
        if (exp_q.size() != 0) begin
            logic [23:0] e;
            e = exp_q.pop_front();
            checks++;
            if (dut_snap() !== e) begin
                errors++;
                $display("FAIL snapshot {BT,WT,T0,T1,T2,T13,T21,T28,T29,TE,TF,TS,locked,sync_err}: got %06h expected %06h at %0t",
                         dut_snap(), e, $time);
            end
        end
    end

    initial begin
        logic [23:0] held;
        rst_n     = 1'b0;
        tg.bit_en = 1'b0;
        tg.origin = 1'b0;
        repeat (3) @(posedge CLOCK);
        #1;
        chk("reset_state", dut_snap(), 24'h0);
        chk("reset_cr", {31'd0, tg.CR}, 32'd0);
        @(negedge CLOCK);
        rst_n = 1'b1;

        // Free-running in HUNT: counts advance, decodes stay low
        run(5);
        drain();
        chk("hunt_bt", tg.BT, 5);
        chk("hunt_t29_forced", tg.T29, 0);

        // Lock on the first origin and count into the word
        step(1'b1);
        run(12);
        drain();
        chk("t2_bt12", tg.BT, 12);
        chk("t2_t13", tg.T13, 1);
        run(17);
        drain();
        chk("t2_bt", tg.BT, 0);
        chk("t2_wt", tg.WT, 1);
        chk("t2_te", tg.TE, 0);
        chk("t2_locked", tg.locked, 1);

        // Asynchronous reset in the middle of a count
        run(7);
        drain();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_state", dut_snap(), 24'h0);
        m_bt = 0; m_wt = 0; m_lock = 0; m_miss = 0; m_err = 0;
        @(negedge CLOCK);
        rst_n = 1'b1;

        // One full revolution with origin on every expected boundary
        step(1'b1);
        run(108 * 29 - 1);
        drain();
        chk("rev_end_bt", tg.BT, 28);
        chk("rev_end_wt", tg.WT, 107);
        chk("rev_end_tf", tg.TF, 1);
        chk("rev_end_t0", tg.T0, 1);
        chk("rev_end_t29", tg.T29, 1);
        chk("rev_end_ts", tg.TS, 1);
        step(1'b1);
        drain();
        chk("rev_origin_no_err", tg.sync_err, 0);
        chk("rev_wrap_wt", tg.WT, 0);

        // bit_en idle: everything holds and CR stays low
        run(3);
        drain();
        held = exp_snap();
        for (int i = 0; i < 50; i++) begin
            @(negedge CLOCK);
            chk("idle_hold", dut_snap(), held);
            chk("idle_cr", tg.CR, 0);
        end

        // Withhold origin for two revolutions
        run(108 * 29 - 4);
        drain();
        chk("miss1_pre_wt", tg.WT, 107);
        step(1'b0);
        drain();
        chk("miss1_err", tg.sync_err, 1);
        chk("miss1_locked", tg.locked, 1);
        run(108 * 29 - 1);
        step(1'b0);
        drain();
        chk("miss2_err", tg.sync_err, 1);
        chk("miss2_unlocked", tg.locked, 0);
        chk("miss2_t1_forced", tg.T1, 0);
        chk("miss2_te_forced", tg.TE, 0);

        // Early origin while locked forces a resync
        step(1'b1);
        run(40 * 29 + 5);
        drain();
        chk("early_pre_wt", tg.WT, 40);
        chk("early_pre_bt", tg.BT, 5);
        step(1'b1);
        drain();
        chk("early_err", tg.sync_err, 1);
        chk("early_bt", tg.BT, 0);
        chk("early_wt", tg.WT, 0);
        chk("early_locked", tg.locked, 1);
        step(1'b0);
        drain();
        chk("early_err_clears", tg.sync_err, 0);
        chk("early_bt_next", tg.BT, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
